sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO; next generation of the team's 16-bit × 8-entry FIFO.
- Generalises data width and depth (power of two).
- Adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a selectable read mode (registered or first-word-fall-through).
- Sits between single-clock producer/consumer blocks as a drop-in buffer.

---
 rtl/sync_fifo_param.sv | 118 +++++++++++
 tb/tb_sync_fifo_param.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and
// a choice of registered or first-word-fall-through read data.
module sync_fifo_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write,
    input  logic              read,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] AF_CNT    = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_CNT    = AE_LEVEL[ADDR_W:0];

    // Thresholds that cannot be met sensibly stop elaboration outright.
    generate
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
            $error("sync_fifo_param: AF_LEVEL must lie in 1..DEPTH");
        end
        if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL) begin : g_bad_ae
            $error("sync_fifo_param: AE_LEVEL must be >= 0 and < AF_LEVEL");
        end
    endgenerate

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_ok, rd_ok, flush;

    // Status flags come only from the registered count, never from read/write.
    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Accept decisions and next-state values for pointers, count and errors.
    always_comb begin
        // NOTE: every output of this block gets a value on every path, so no latch is inferred.
        flush       = reset | clear;
        wr_ok       = write & (~full | read);
        rd_ok       = read & ~empty;
        wr_ptr_d    = wr_ptr_q + ADDR_W'(wr_ok);
        rd_ptr_d    = rd_ptr_q + ADDR_W'(rd_ok);
        count_d     = count_q + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
        overflow_d  = overflow_q | (write & full & ~read);
        underflow_d = underflow_q | (read & empty);
    end

    // Control state; reset and clear both flush and win over any access.
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array: written only on an accepted write outside a flush.
    always_ff @(posedge clock) begin
        // NOTE: the array has no reset; a flush only moves the pointers, which keeps it in plain RAM.
        if (!flush && wr_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of the queue is presented directly; meaningless while empty.
            assign data_out = mem_q[rd_ptr_q];
        end else begin : g_reg
            logic [DATA_W-1:0] rdata_q;

            // Registered read port: captures the head word on an accepted read.
            always_ff @(posedge clock) begin
                if (flush) begin
                    rdata_q <= '0;
                end else if (rd_ok) begin
                    rdata_q <= mem_q[rd_ptr_q];
                end
            end

            assign data_out = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param. Three instances share one stimulus
// stream: defaults (registered read), FWFT=1, and AF_LEVEL=4/AE_LEVEL=1.
// A queue-based reference model tracks occupancy, sticky errors and read data.
module tb_sync_fifo_param;

    logic        clock;
    logic        reset, clear, write, read;
    logic [15:0] data_in;

    logic [15:0] dout [3];
    logic [3:0]  cnt  [3];
    logic [2:0]  full_v, empty_v, af_v, ae_v, ov_v, un_v;

    int n_tests = 0;
    int n_fail  = 0;

    sync_fifo_param u_reg (
        .clock(clock), .reset(reset), .clear(clear), .data_in(data_in),
        .write(write), .read(read), .data_out(dout[0]), .full(full_v[0]),
        .empty(empty_v[0]), .almost_full(af_v[0]), .almost_empty(ae_v[0]),
        .count(cnt[0]), .overflow(ov_v[0]), .underflow(un_v[0])
    );

    sync_fifo_param #(.FWFT(1)) u_fwft (
        .clock(clock), .reset(reset), .clear(clear), .data_in(data_in),
        .write(write), .read(read), .data_out(dout[1]), .full(full_v[1]),
        .empty(empty_v[1]), .almost_full(af_v[1]), .almost_empty(ae_v[1]),
        .count(cnt[1]), .overflow(ov_v[1]), .underflow(un_v[1])
    );

    sync_fifo_param #(.AF_LEVEL(4), .AE_LEVEL(1)) u_thr (
        .clock(clock), .reset(reset), .clear(clear), .data_in(data_in),
        .write(write), .read(read), .data_out(dout[2]), .full(full_v[2]),
        .empty(empty_v[2]), .almost_full(af_v[2]), .almost_empty(ae_v[2]),
        .count(cnt[2]), .overflow(ov_v[2]), .underflow(un_v[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    localparam int DEPTH = 8;
    int          af_lvl [3] = '{6, 6, 4};
    int          ae_lvl [3] = '{2, 2, 1};
    logic [15:0] mq [$];
    logic        m_ov, m_un;
    logic [15:0] m_dout;

    task automatic model_step(input logic rst, clr, w, r, input logic [15:0] d);
        bit is_full, is_empty, rd_ok, wr_ok;
        if (rst || clr) begin
            mq.delete();
            m_ov   = 1'b0;
            m_un   = 1'b0;
            m_dout = 16'h0;
        end else begin
            is_full  = (mq.size() == DEPTH);
            is_empty = (mq.size() == 0);
            rd_ok    = r && !is_empty;
            wr_ok    = w && (!is_full || r);
            if (w && is_full && !r) m_ov = 1'b1;
            if (r && is_empty)      m_un = 1'b1;
            if (rd_ok) m_dout = mq.pop_front();
            if (wr_ok) mq.push_back(d);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("count[%0d]", i), 32'(cnt[i]), n);
            check($sformatf("full[%0d]", i), 32'(full_v[i]), 32'(n == DEPTH));
            check($sformatf("empty[%0d]", i), 32'(empty_v[i]), 32'(n == 0));
            check($sformatf("almost_full[%0d]", i), 32'(af_v[i]), 32'(n >= af_lvl[i]));
            check($sformatf("almost_empty[%0d]", i), 32'(ae_v[i]), 32'(n <= ae_lvl[i]));
            check($sformatf("overflow[%0d]", i), 32'(ov_v[i]), 32'(m_ov));
            check($sformatf("underflow[%0d]", i), 32'(un_v[i]), 32'(m_un));
            if (i != 1) check($sformatf("data_out[%0d]", i), 32'(dout[i]), 32'(m_dout));
            else if (n != 0) check("data_out_fwft", 32'(dout[1]), 32'(mq[0]));
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check 1 time unit later.
    task automatic cycle(input logic rst, clr, w, r, input logic [15:0] d);
        reset   = rst;
        clear   = clr;
        write   = w;
        read    = r;
        data_in = d;
        @(posedge clock);
        model_step(rst, clr, w, r, d);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic wr(input logic [15:0] d);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic rd();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    // ---------------- directed table for the default instance ----------------
    typedef struct {
        logic        rst, clr, wr, rd;
        logic [15:0] din;
        int          exp_count;
        logic        exp_full, exp_empty, exp_af, exp_ae, exp_ov, exp_un;
        logic [15:0] exp_dout;
    } vec_t;

    vec_t vecs [$];

    initial begin
        vec_t v;
        reset = 1'b0; clear = 1'b0; write = 1'b0; read = 1'b0; data_in = 16'h0;

        // Fill, overflow, then drain of the default instance (registered read).
        vecs.push_back('{1, 0, 0, 0, 16'h0, 0, 0, 1, 0, 1, 0, 0, 16'h0});
        for (int i = 1; i <= 8; i++)
            vecs.push_back('{0, 0, 1, 0, 16'(i), i, (i == 8), 0, (i >= 6), (i <= 2), 0, 0, 16'h0});
        vecs.push_back('{0, 0, 1, 0, 16'h0009, 8, 1, 0, 1, 0, 1, 0, 16'h0});
        for (int k = 1; k <= 8; k++)
            vecs.push_back('{0, 0, 0, 1, 16'h0, 8 - k, 0, (k == 8), (8 - k >= 6), (8 - k <= 2), 1, 0, 16'(k)});

        foreach (vecs[j]) begin
            v = vecs[j];
            cycle(v.rst, v.clr, v.wr, v.rd, v.din);
            check($sformatf("vec%0d count", j), 32'(cnt[0]), v.exp_count);
            check($sformatf("vec%0d full", j), 32'(full_v[0]), 32'(v.exp_full));
            check($sformatf("vec%0d empty", j), 32'(empty_v[0]), 32'(v.exp_empty));
            check($sformatf("vec%0d af", j), 32'(af_v[0]), 32'(v.exp_af));
            check($sformatf("vec%0d ae", j), 32'(ae_v[0]), 32'(v.exp_ae));
            check($sformatf("vec%0d ov", j), 32'(ov_v[0]), 32'(v.exp_ov));
            check($sformatf("vec%0d un", j), 32'(un_v[0]), 32'(v.exp_un));
            check($sformatf("vec%0d dout", j), 32'(dout[0]), 32'(v.exp_dout));
        end

        // Wrap-around: pointers pass DEPTH-1 -> 0 with data kept in order.
        do_reset();
        for (int i = 0; i < 5; i++) wr(16'h0100 + 16'(i));
        for (int i = 0; i < 5; i++) rd();
        for (int i = 0; i < 6; i++) wr(16'h0200 + 16'(i));
        check("wrap count", 32'(cnt[0]), 6);
        for (int i = 0; i < 6; i++) begin
            rd();
            check($sformatf("wrap data%0d", i), 32'(dout[0]), 32'(16'h0200 + 16'(i)));
        end
        check("wrap empty", 32'(empty_v[0]), 1);

        // Simultaneous read+write while full, then while empty.
        do_reset();
        for (int i = 0; i < 8; i++) wr(16'h0300 + 16'(i));
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0400 + 16'(i));
            check("rw_full count", 32'(cnt[0]), 8);
            check("rw_full full", 32'(full_v[0]), 1);
            check("rw_full ov", 32'(ov_v[0]), 0);
            check("rw_full dout", 32'(dout[0]), 32'(16'h0300 + 16'(i)));
        end
        do_reset();
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h5555);
        check("rw_empty count", 32'(cnt[0]), 1);
        check("rw_empty un", 32'(un_v[0]), 1);

        // First-word-fall-through behaviour.
        do_reset();
        wr(16'hABCD);
        check("fwft first word", 32'(dout[1]), 32'hABCD);
        check("fwft not empty", 32'(empty_v[1]), 0);
        wr(16'h1234);
        check("fwft head held", 32'(dout[1]), 32'hABCD);
        rd();
        check("fwft next word", 32'(dout[1]), 32'h1234);
        rd();
        check("fwft empty at end", 32'(empty_v[1]), 1);

        // Clear during operation with a pending write and a set overflow.
        do_reset();
        for (int i = 0; i < 8; i++) wr(16'h0600 + 16'(i));
        wr(16'h06FF);
        for (int i = 0; i < 3; i++) rd();
        check("pre-clear count", 32'(cnt[0]), 5);
        check("pre-clear ov", 32'(ov_v[0]), 1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0777);
        check("clear count", 32'(cnt[0]), 0);
        check("clear empty", 32'(empty_v[0]), 1);
        check("clear ov", 32'(ov_v[0]), 0);
        check("clear dout", 32'(dout[0]), 0);

        // Reset pulse in the middle of a write burst.
        for (int i = 0; i < 3; i++) wr(16'h0800 + 16'(i));
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h0888);
        check("burst reset count", 32'(cnt[0]), 0);
        wr(16'h0900);
        wr(16'h0901);
        rd();
        check("after reset data", 32'(dout[0]), 32'h0900);

        // Thresholds on the AF=4/AE=1 instance, filling then draining.
        do_reset();
        check("thr ae at 0", 32'(ae_v[2]), 1);
        for (int k = 1; k <= 8; k++) begin
            wr(16'h0A00 + 16'(k));
            check($sformatf("thr fill ae%0d", k), 32'(ae_v[2]), 32'(k <= 1));
            check($sformatf("thr fill af%0d", k), 32'(af_v[2]), 32'(k >= 4));
        end
        for (int k = 7; k >= 0; k--) begin
            rd();
            check($sformatf("thr drain ae%0d", k), 32'(ae_v[2]), 32'(k <= 1));
            check($sformatf("thr drain af%0d", k), 32'(af_v[2]), 32'(k >= 4));
        end

        // Randomised traffic with shifting read/write bias and rare flushes.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int wp;
            logic rst_r, clr_r, w_r, r_r;
            wp    = ((i / 250) % 2 == 0) ? 70 : 30;
            rst_r = ($urandom_range(0, 299) == 0);
            clr_r = ($urandom_range(0, 149) == 0);
            w_r   = ($urandom_range(0, 99) < wp);
            r_r   = ($urandom_range(0, 99) < (100 - wp));
            cycle(rst_r, clr_r, w_r, r_r, 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
